// File: rtl/ask_rx_pkg.sv
// Shared types and helpers for the ASK receive path.
// Sample width, midscale, carrier FSM states and the rectifier.
package ask_rx_pkg;

    localparam int DW = 10;
    localparam int EW = DW - 1;
    localparam logic [DW-1:0] MID = {1'b1, {EW{1'b0}}};

    typedef enum logic {
        SEARCH,
        LOCKED
    } car_state_t;

    // |d - c|, clipped to the largest magnitude an EW-bit envelope can hold
    function automatic logic [EW-1:0] rectify(
        input logic [DW-1:0] d,
        input logic [DW-1:0] c
    );
        logic [DW-1:0] mag;
        mag = (d >= c) ? (d - c) : (c - d);
        rectify = mag[DW-1] ? {EW{1'b1}} : mag[EW-1:0];
    endfunction

endpackage

// File: rtl/ask_peak_win.sv
// Rectifier, window counter and peak hold producing the latched envelope.
// ASK_DC_TRACK_EN replaces fixed midscale with a per-window min/max DC estimate.
module ask_peak_win
    import ask_rx_pkg::*;
#(
    parameter int WIN = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_valid,
    input  logic [DW-1:0] data_in,
    output logic          win_done,
    output logic [EW-1:0] win_peak,
    output logic [EW-1:0] env,
    output logic          env_valid
);

    localparam int CW = $clog2(WIN);

    logic [CW-1:0] cnt;
    logic [EW-1:0] peak;
    logic [EW-1:0] rect;
    logic [DW-1:0] center;

    assign rect     = rectify(data_in, center);
    assign win_peak = (rect > peak) ? rect : peak;
    assign win_done = sample_valid && (cnt == CW'(WIN - 1));

`ifdef ASK_DC_TRACK_EN
    logic [DW-1:0] dc;
    logic [DW-1:0] mn;
    logic [DW-1:0] mx;
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    logic [DW:0]   mid_sum;

    assign lo      = (data_in < mn) ? data_in : mn;
    assign hi      = (data_in > mx) ? data_in : mx;
    assign mid_sum = {1'b0, lo} + {1'b0, hi};
    assign center  = dc;

    // New estimate applies from the first sample of the following window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc <= MID;
            mn <= {DW{1'b1}};
            mx <= '0;
        end else if (sample_valid) begin
            if (win_done) begin
                dc <= mid_sum[DW:1];
                mn <= {DW{1'b1}};
                mx <= '0;
            end else begin
                mn <= lo;
                mx <= hi;
            end
        end
    end
`else
    assign center = MID;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            peak      <= '0;
            env       <= '0;
            env_valid <= 1'b0;
        end else begin
            env_valid <= win_done;
            if (sample_valid) begin
                if (win_done) begin
                    cnt  <= '0;
                    peak <= '0;
                    env  <= win_peak;
                end else begin
                    cnt  <= cnt + 1'b1;
                    peak <= win_peak;
                end
            end
        end
    end

endmodule

// File: rtl/ask_env_slicer.sv
// ASK envelope slicer: hysteresis bit decision and carrier search/lock FSM.
// Optional ASK_DC_TRACK_EN enables DC tracking inside ask_peak_win.
module ask_env_slicer
    import ask_rx_pkg::*;
#(
    parameter int WIN       = 64,
    parameter int TH_HI     = 200,
    parameter int TH_LO     = 120,
    parameter int LOCK_WINS = 4,
    parameter int LOSS_WINS = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_valid,
    input  logic [DW-1:0] data_in,
    output logic [EW-1:0] env,
    output logic          env_valid,
    output logic          bit_out,
    output logic          carrier_det
);

    localparam int RMAX = (LOCK_WINS > LOSS_WINS) ? LOCK_WINS : LOSS_WINS;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [EW-1:0] HI_T   = EW'(TH_HI);
    localparam logic [EW-1:0] LO_T   = EW'(TH_LO);
    localparam logic [RW-1:0] LOCK_R = RW'(LOCK_WINS);
    localparam logic [RW-1:0] LOSS_R = RW'(LOSS_WINS);

    logic          win_done;
    logic [EW-1:0] win_peak;
    logic          above;
    logic [RW-1:0] run;
    logic [RW-1:0] run_inc;
    car_state_t    state;

    ask_peak_win #(
        .WIN (WIN)
    ) u_peak (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .data_in      (data_in),
        .win_done     (win_done),
        .win_peak     (win_peak),
        .env          (env),
        .env_valid    (env_valid)
    );

    assign above   = (win_peak >= LO_T);
    assign run_inc = run + 1'b1;

    // Decisions use the envelope being latched so they land with env_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEARCH;
            run         <= '0;
            bit_out     <= 1'b0;
            carrier_det <= 1'b0;
        end else if (win_done) begin
            if (win_peak >= HI_T) begin
                bit_out <= 1'b1;
            end else if (!above) begin
                bit_out <= 1'b0;
            end
            unique case (state)
                SEARCH: begin
                    if (!above) begin
                        run <= '0;
                    end else if (run_inc == LOCK_R) begin
                        state       <= LOCKED;
                        run         <= '0;
                        carrier_det <= 1'b1;
                    end else begin
                        run <= run_inc;
                    end
                end
                LOCKED: begin
                    if (above) begin
                        run <= '0;
                    end else if (run_inc == LOSS_R) begin
                        state       <= SEARCH;
                        run         <= '0;
                        carrier_det <= 1'b0;
                    end else begin
                        run <= run_inc;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ask_env_slicer.sv
// Self-checking bench for ask_env_slicer against a window-list reference model.
// Build with ASK_DC_TRACK_EN to also exercise DC tracking.
module tb_ask_env_slicer;
    import ask_rx_pkg::*;

    localparam int WIN       = 64;
    localparam int TH_HI     = 200;
    localparam int TH_LO     = 120;
    localparam int LOCK_WINS = 4;
    localparam int LOSS_WINS = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] data_in = 10'd512;
    logic [EW-1:0] env;
    logic          env_valid;
    logic          bit_out;
    logic          carrier_det;

    always #5 clk = ~clk;

    ask_env_slicer #(
        .WIN       (WIN),
        .TH_HI     (TH_HI),
        .TH_LO     (TH_LO),
        .LOCK_WINS (LOCK_WINS),
        .LOSS_WINS (LOSS_WINS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .data_in      (data_in),
        .env          (env),
        .env_valid    (env_valid),
        .bit_out      (bit_out),
        .carrier_det  (carrier_det)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: rectified samples of the open window, plus decisions
    int q[$];
    int raws[$];
    int m_env, m_vld, m_bit, m_car, m_run, m_dc;

    function automatic int rect_of(input int d, input int c);
        int r;
        r = d - c;
        if (r < 0) r = -r;
        if (r > 511) r = 511;
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        raws.delete();
        m_env = 0; m_vld = 0; m_bit = 0; m_car = 0; m_run = 0; m_dc = 512;
    endtask

    task automatic model_accept(input int d);
        int m, lo, hi;
        q.push_back(rect_of(d, m_dc));
        raws.push_back(d);
        if (q.size() == WIN) begin
            m = 0; lo = 1023; hi = 0;
            foreach (q[i]) if (q[i] > m) m = q[i];
            foreach (raws[i]) begin
                if (raws[i] < lo) lo = raws[i];
                if (raws[i] > hi) hi = raws[i];
            end
            m_env = m;
            m_vld = 1;
            if (m >= TH_HI) m_bit = 1;
            else if (m < TH_LO) m_bit = 0;
            if (m_car == 0) begin
                m_run = (m >= TH_LO) ? m_run + 1 : 0;
                if (m_run == LOCK_WINS) begin m_car = 1; m_run = 0; end
            end else begin
                m_run = (m < TH_LO) ? m_run + 1 : 0;
                if (m_run == LOSS_WINS) begin m_car = 0; m_run = 0; end
            end
`ifdef ASK_DC_TRACK_EN
            m_dc = (lo + hi) / 2;
`endif
            q.delete();
            raws.delete();
        end
    endtask

    // One clock: compare last edge's outputs, then drive the next input
    task automatic step(input bit v, input int d);
        @(negedge clk);
        check("env_valid", env_valid, m_vld);
        check("env", env, m_env);
        check("bit_out", bit_out, m_bit);
        check("carrier_det", carrier_det, m_car);
        sample_valid = v;
        data_in = d[DW-1:0];
        m_vld = 0;
        if (v) model_accept(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sample_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_env", env, 0);
        check("rst_vld", env_valid, 0);
        check("rst_bit", bit_out, 0);
        check("rst_car", carrier_det, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_win(input int pk, input int gap);
        int idx, d, off;
        idx = $urandom_range(0, WIN - 1);
        for (int i = 0; i < WIN; i++) begin
            if (i == idx) begin
                d = ($urandom_range(0, 1) == 1) ? 512 + pk : 512 - pk;
            end else begin
                off = $urandom_range(0, pk);
                d = ($urandom_range(0, 1) == 1) ? 512 + off : 512 - off;
            end
            step(1'b1, d);
            repeat (gap) step(1'b0, 512);
        end
    endtask

    int hy_pk[4]  = '{250, 150, 100, 150};
    int hy_bit[4] = '{1, 1, 0, 0};

    initial begin
        int idx;
        model_reset();
        do_reset();

        // Reset mid-window discards the partial window
        repeat (30) step(1'b1, 1023);
        do_reset();
        repeat (64) step(1'b1, 512);
        step(1'b0, 512);
        check("midrst_vld", env_valid, 1);
        check("midrst_env", env, 0);

        // Full-scale tone
        for (int i = 0; i < WIN; i++) step(1'b1, (i % 2 == 1) ? 0 : 1023);
        step(1'b0, 512);
        check("fs_vld", env_valid, 1);
        check("fs_env", env, 511);
        check("fs_bit", bit_out, 1);

        // Hysteresis
        do_reset();
        for (int w = 0; w < 4; w++) begin
            send_win(hy_pk[w], 0);
            step(1'b0, 512);
            check("hy_env", env, hy_pk[w]);
            check("hy_bit", bit_out, hy_bit[w]);
        end

        // Lock then loss
        do_reset();
        for (int w = 0; w < LOCK_WINS; w++) begin
            send_win(300, 0);
            step(1'b0, 512);
            check("lock_car", carrier_det, (w == LOCK_WINS - 1) ? 1 : 0);
        end
        for (int w = 0; w < LOSS_WINS; w++) begin
            send_win(50, 0);
            step(1'b0, 512);
            check("loss_car", carrier_det, (w < LOSS_WINS - 1) ? 1 : 0);
        end

        // Gapped strobes
        do_reset();
        idx = $urandom_range(0, WIN - 1);
        for (int i = 0; i < WIN; i++) begin
            step(1'b1, (i == idx) ? 700 : 512);
            step(1'b0, 512);
            step(1'b0, 512);
        end
        check("gap_env", env, 188);
        step(1'b0, 512);
        check("gap_vld_end", env_valid, 0);

        // Random traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1023));
        end
        for (int w = 0; w < 6; w++) send_win($urandom_range(0, 511), $urandom_range(0, 1));
        step(1'b0, 512);

`ifdef ASK_DC_TRACK_EN
        do_reset();
        for (int i = 0; i < WIN; i++) begin
            step(1'b1, (i == 0) ? 600 : (i == 1) ? 800 : 600 + $urandom_range(0, 200));
        end
        idx = $urandom_range(0, WIN - 1);
        for (int i = 0; i < WIN; i++) step(1'b1, (i == idx) ? 950 : 700);
        step(1'b0, 512);
        check("dc_env", env, 250);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ask_env_slicer.md
Name: ask_env_slicer

Overview:
Downstream consumer of the 10-bit ADC capture register in the AM/ASK receive path.
- Rectifies offset-binary samples about midscale.
- Extracts a windowed peak envelope.
- Slices the envelope into a demodulated ASK bit using hysteresis.
- Reports carrier presence through a search/lock FSM.
- Output feeds the bit-timing/UART recovery stage and the envelope display path.

Parameters:
- DW, 10, ADC sample width, offset binary.
- WIN, 64, accepted samples per envelope window (power of 2, 2..1024).
- TH_HI, 200, envelope level at or above which bit_out sets.
- TH_LO, 120, envelope level below which bit_out clears; must be < TH_HI.
- LOCK_WINS, 4, consecutive windows with env >= TH_LO required to declare carrier.
- LOSS_WINS, 16, consecutive windows with env < TH_LO required to drop carrier.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- sample_valid, input, 1: one-cycle strobe; data_in is valid this cycle.
- data_in, input, DW: ADC sample, offset binary, midscale 2^(DW-1).
- env, output, DW-1: latched peak envelope of the last complete window.
- env_valid, output, 1: one-cycle pulse when env updates.
- bit_out, output, 1: demodulated ASK level.
- carrier_det, output, 1: high while the FSM is in LOCKED.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: env=0, env_valid=0, bit_out=0, carrier_det=0.
  - Internal: window counter=0, peak=0, FSM=SEARCH, run counter=0.
  - Assertion at any point aborts the window in progress; no partial-window env is ever emitted.
- Rectify: rect = |data_in − 2^(DW−1)|, saturated to 2^(DW−1)−1.
  - For DW=10: data_in 0 gives 511; data_in 512 gives 0; data_in 1023 gives 511.
- Samples are accepted only when sample_valid=1. With sample_valid=0, all state holds and env_valid=0.
- Window accumulation:
  - Each accepted sample sets peak ← max(peak, rect) and increments the counter.
  - On the accepted sample where counter=WIN−1:
    - env ← max(peak, rect);
    - peak ← 0;
    - counter wraps to 0;
    - env_valid=1 on the next cycle.
  - Latency: env/env_valid update 1 clk after the WIN-th sample strobe.
  - Back-to-back strobes every clk are supported with no gaps.
- Slicer (evaluated on the cycle env updates, applied with env_valid):
  - env ≥ TH_HI → bit_out=1.
  - env < TH_LO → bit_out=0.
  - Otherwise bit_out holds.
  - bit_out changes only in the env_valid cycle.
- Carrier FSM, two states, advanced only on window completion:
  - SEARCH:
    - env ≥ TH_LO increments run; env < TH_LO clears run.
    - When run reaches LOCK_WINS, go to LOCKED and clear run.
  - LOCKED:
    - env < TH_LO increments run; env ≥ TH_LO clears run.
    - When run reaches LOSS_WINS, go to SEARCH and clear run.
  - carrier_det=1 exactly in LOCKED and changes in the same cycle as env_valid.
  - run counter width is clog2(max(LOCK_WINS, LOSS_WINS)+1) and never overflows.
- bit_out is not gated by carrier_det; downstream qualifies it.

Optional Feature:
- Macro: ASK_DC_TRACK_EN.
- Defined:
  - Midscale is replaced by a tracked DC estimate.
  - Per-window min and max of raw data_in are captured.
  - At window end, dc ← (min+max)>>1; dc takes effect for the next window.
  - dc resets to 2^(DW−1).
  - Rectification saturation is unchanged.
- Undefined: fixed midscale; no min/max registers are synthesised.

Decomposition:
- Shared package ask_rx_pkg contains:
  - DW;
  - midscale constant MID = 2^(DW−1);
  - FSM state enum {SEARCH, LOCKED};
  - rectify/saturate function.
- One sub-module, ask_peak_win: rectifier, window counter and peak hold, producing env/env_valid.
- Top level holds the slicer and carrier FSM.

Test Plan:
- Reset mid-window: 30 strobes at data_in=1023, then rst_n pulse, then 64 strobes at 512 → no env_valid before the 64th post-reset strobe; env=0.
- Full-scale tone: alternating 1023/0, 64 strobes → env=511; env_valid 1 clk after the 64th strobe; bit_out=1.
- Hysteresis: windows with peaks 250, 150, 100, 150 → bit_out 1, 1, 0, 0.
- Lock/loss: 4 windows at env 300 → carrier_det rises on the 4th env_valid. Then 15 windows at env 50 keep it high; the 16th drops it.
- Gapped strobes: sample_valid every 3rd clk, 64 samples with one at 700 → env=188, single env_valid pulse.
- With ASK_DC_TRACK_EN: window 1 spans 600..800 so dc=700. In window 2, data_in=700 gives rect=0, and 950 gives 250 → env=250.
